// File: rtl/memcard_pkg.sv
// ============================================================================
// Module : memcard_pkg
// Brief  : Shared states and sizing constants for the memory-card transfer path.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package memcard_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_REQ  = 3'd1,
        LOAD_XFER = 3'd2,
        SAVE_REQ  = 3'd3,
        SAVE_XFER = 3'd4,
        NEXT      = 3'd5
    } state_t;

    localparam int unsigned c_SECTORS_CART = 4;
    localparam int unsigned c_SECTORS_CD   = 16;
    localparam int unsigned c_SECTOR_WORDS = 256;
    localparam int unsigned c_WORD_AW      = $clog2(c_SECTOR_WORDS);

    function automatic logic [3:0] last_sector(input logic cd_mode);
        return cd_mode ? 4'(c_SECTORS_CD - 1) : 4'(c_SECTORS_CART - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/memcard_idle_timer.sv
// ============================================================================
// Module : memcard_idle_timer
// Brief  : Counts idle cycles since the last card write; fires while armed at LIMIT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memcard_idle_timer #(
    parameter logic [23:0] LIMIT = 24'd4_800_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic restart,
    input  logic arm,
    output logic fire
);

    logic [23:0] r_count;

    // Saturates at LIMIT so a blocked save keeps retrying until the card is clean
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_count <= 24'd0;
        end else if (restart) begin
            r_count <= 24'd0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + 24'd1;
        end
    end

    assign fire = arm & ~restart & (r_count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/memcard_xfer_ctrl.sv
// ============================================================================
// Module : memcard_xfer_ctrl
// Brief  : Moves the NeoGeo memory-card image between SD sectors and card RAM.
//          Optional autosave when MEMCARD_AUTOSAVE_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module memcard_xfer_ctrl
    import memcard_pkg::*;
#(
    parameter logic [23:0] AUTOSAVE_IDLE = 24'd4_800_000,
    parameter logic [31:0] LBA_BASE      = 32'd0
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 SYSTEM_CDx,
    input  logic                 card_wr_pulse,
    input  logic                 img_mounted,
    input  logic                 img_size_nz,
    input  logic                 img_readonly,
    input  logic                 save_req,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    input  logic                 sd_ack,
    input  logic [c_WORD_AW-1:0] sd_buff_addr,
    input  logic                 sd_buff_wr,
    output logic [11:0]          memcard_addr,
    output logic                 memcard_wr,
    output logic                 busy,
    output logic                 loaded,
    output logic                 dirty
);

    state_t     r_state, w_next;
    logic [3:0] r_sector;
    logic       r_cd, r_op_load, r_ack_q;
    logic       r_pend_mount, r_pend_save, r_loaded, r_dirty;

    logic w_auto_fire, w_mount_pend, w_save_ok, w_save_in, w_save_pend;
    logic w_start_load, w_start_save, w_empty_mount, w_load_done, w_sector_inc;

`ifdef MEMCARD_AUTOSAVE_EN
    memcard_idle_timer #(
        .LIMIT   (AUTOSAVE_IDLE)
    ) u_idle_timer (
        .clk_sys (clk_sys),
        .reset   (reset),
        .restart (card_wr_pulse),
        .arm     (r_dirty),
        .fire    (w_auto_fire)
    );
`else
    logic w_unused_autosave;
    assign w_unused_autosave = ^AUTOSAVE_IDLE;
    assign w_auto_fire       = 1'b0;
`endif

    // Requests arriving in the current cycle are seen in IDLE without a pending-flag delay
    assign w_mount_pend = r_pend_mount | img_mounted;
    assign w_save_ok    = r_loaded & ~img_readonly;
    assign w_save_in    = save_req | w_auto_fire;
    assign w_save_pend  = r_pend_save | (w_save_in & w_save_ok);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_start_load  = 1'b0;
        w_start_save  = 1'b0;
        w_empty_mount = 1'b0;
        w_load_done   = 1'b0;
        w_sector_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mount_pend) begin
                    if (img_size_nz) begin
                        w_next       = LOAD_REQ;
                        w_start_load = 1'b1;
                    end else begin
                        w_empty_mount = 1'b1;
                    end
                end else if (w_save_pend && w_save_ok) begin
                    w_next       = SAVE_REQ;
                    w_start_save = 1'b1;
                end
            end
            LOAD_REQ:  if (sd_ack) w_next = LOAD_XFER;
            SAVE_REQ:  if (sd_ack) w_next = SAVE_XFER;
            LOAD_XFER,
            SAVE_XFER: if (r_ack_q && !sd_ack) w_next = NEXT;
            NEXT: begin
                if (r_sector < last_sector(r_cd)) begin
                    w_sector_inc = 1'b1;
                    w_next       = r_op_load ? LOAD_REQ : SAVE_REQ;
                end else begin
                    w_load_done = r_op_load;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sector     <= 4'd0;
            r_cd         <= 1'b0;
            r_op_load    <= 1'b0;
            r_ack_q      <= 1'b0;
            r_pend_mount <= 1'b0;
            r_pend_save  <= 1'b0;
            r_loaded     <= 1'b0;
            r_dirty      <= 1'b0;
        end else begin
            r_ack_q <= sd_ack;

            if (r_state == IDLE && w_mount_pend) begin
                r_pend_mount <= 1'b0;
            end else if (img_mounted) begin
                r_pend_mount <= 1'b1;
            end

            // IDLE always consumes a pending save: serviced, overridden by a mount, or no longer allowed
            if (r_state == IDLE) begin
                r_pend_save <= 1'b0;
            end else if (w_save_in && w_save_ok) begin
                r_pend_save <= 1'b1;
            end

            if (r_state == IDLE && w_mount_pend) begin
                r_loaded <= ~img_size_nz;
            end else if (w_load_done) begin
                r_loaded <= 1'b1;
            end

            // A card write wins over the save-start clear so a racing write is never lost
            if (card_wr_pulse || w_empty_mount) begin
                r_dirty <= 1'b1;
            end else if (w_start_save) begin
                r_dirty <= 1'b0;
            end

            if (w_start_load || w_start_save) begin
                r_sector  <= 4'd0;
                r_cd      <= SYSTEM_CDx;
                r_op_load <= w_start_load;
            end else if (w_sector_inc) begin
                r_sector <= r_sector + 4'd1;
            end
        end
    end

    assign sd_rd        = (r_state == LOAD_REQ);
    assign sd_wr        = (r_state == SAVE_REQ);
    assign sd_lba       = LBA_BASE + {28'd0, r_sector};
    assign memcard_addr = {r_sector, sd_buff_addr};
    assign memcard_wr   = sd_buff_wr & sd_ack & (r_state == LOAD_XFER);
    assign busy         = (r_state != IDLE);
    assign loaded       = r_loaded;
    assign dirty        = r_dirty;

endmodule

`default_nettype wire

// File: tb/tb_memcard_xfer_ctrl.sv
// ============================================================================
// Module : tb_memcard_xfer_ctrl
// Brief  : Directed bench for memcard_xfer_ctrl with a simple HPS sector model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_memcard_xfer_ctrl;
    import memcard_pkg::*;

    localparam logic [31:0] c_LBA_BASE = 32'h0000_1000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        SYSTEM_CDx = 1'b0;
    logic        card_wr_pulse = 1'b0;
    logic        img_mounted = 1'b0;
    logic        img_size_nz = 1'b0;
    logic        img_readonly = 1'b0;
    logic        save_req = 1'b0;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack = 1'b0;
    logic [7:0]  sd_buff_addr = 8'd0;
    logic        sd_buff_wr = 1'b0;
    logic [11:0] memcard_addr;
    logic        memcard_wr, busy, loaded, dirty;

    int n_checks = 0;
    int n_pass   = 0;
    int shakes;
    int hits;
    int k;

    memcard_xfer_ctrl #(
        .AUTOSAVE_IDLE (24'd100),
        .LBA_BASE      (c_LBA_BASE)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .SYSTEM_CDx    (SYSTEM_CDx),
        .card_wr_pulse (card_wr_pulse),
        .img_mounted   (img_mounted),
        .img_size_nz   (img_size_nz),
        .img_readonly  (img_readonly),
        .save_req      (save_req),
        .sd_lba        (sd_lba),
        .sd_rd         (sd_rd),
        .sd_wr         (sd_wr),
        .sd_ack        (sd_ack),
        .sd_buff_addr  (sd_buff_addr),
        .sd_buff_wr    (sd_buff_wr),
        .memcard_addr  (memcard_addr),
        .memcard_wr    (memcard_wr),
        .busy          (busy),
        .loaded        (loaded),
        .dirty         (dirty)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Counts cycles in which any sector request is raised
    task automatic quiet(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (sd_rd || sd_wr) cnt++;
            step();
        end
    endtask

    // HPS model: answers nsec requests; optionally pulses card write or mount in one save sector
    task automatic hps_serve(input int nsec, input bit is_load, input int pulse_sector,
                             input bit pulse_mount, output int cnt);
        int wait_cyc;
        int lba_err;
        int data_err;
        bit timed_out;
        cnt = 0; lba_err = 0; data_err = 0; timed_out = 1'b0;
        for (int s = 0; s < nsec; s++) begin
            wait_cyc = 0;
            while (!(is_load ? sd_rd : sd_wr) && wait_cyc < 64) begin
                step();
                wait_cyc++;
            end
            if (wait_cyc >= 64) begin
                timed_out = 1'b1;
                break;
            end
            cnt++;
            if (sd_lba !== c_LBA_BASE + 32'(s) || busy !== 1'b1) lba_err++;
            sd_ack = 1'b1;
            step();
            if (sd_rd !== 1'b0 || sd_wr !== 1'b0) data_err++;
            if (is_load) begin
                for (int w = 0; w < c_SECTOR_WORDS; w++) begin
                    sd_buff_addr = 8'(w);
                    sd_buff_wr   = 1'b1;
                    #1;
                    if (memcard_wr !== 1'b1 || memcard_addr !== {4'(s), 8'(w)}) data_err++;
                    step();
                end
                sd_buff_wr = 1'b0;
            end else begin
                sd_buff_addr = 8'd7;
                sd_buff_wr   = 1'b1;
                #1;
                if (memcard_wr !== 1'b0) data_err++;
                step();
                sd_buff_wr = 1'b0;
                if (s == pulse_sector) begin
                    if (pulse_mount) img_mounted = 1'b1;
                    else card_wr_pulse = 1'b1;
                    step();
                    img_mounted   = 1'b0;
                    card_wr_pulse = 1'b0;
                end
                step(2);
            end
            sd_ack = 1'b0;
            step();
        end
        check("hps_timeout", 32'(timed_out), 32'd0);
        check(is_load ? "load_lba_seq" : "save_lba_seq", 32'(lba_err), 32'd0);
        check(is_load ? "load_card_wr" : "save_no_card_wr", 32'(data_err), 32'd0);
    endtask

    initial begin
        step(3);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_loaded",  32'(loaded),     32'd0);
        check("rst_dirty",   32'(dirty),      32'd0);
        check("rst_sd_rd",   32'(sd_rd),      32'd0);
        check("rst_sd_wr",   32'(sd_wr),      32'd0);
        check("rst_card_wr", 32'(memcard_wr), 32'd0);
        check("rst_lba",     sd_lba,          c_LBA_BASE);
        reset = 1'b0;
        step(2);

        // Cart-mode load of a non-empty image
        SYSTEM_CDx  = 1'b0;
        img_size_nz = 1'b1;
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        check("load_start_busy", 32'(busy), 32'd1);
        hps_serve(4, 1'b1, -1, 1'b0, shakes);
        check("load_shakes", 32'(shakes), 32'd4);
        quiet(20, hits);
        check("load_no_extra_req", 32'(hits), 32'd0);
        check("load_loaded", 32'(loaded), 32'd1);
        check("load_busy",   32'(busy),   32'd0);
        check("load_dirty",  32'(dirty),  32'd0);

`ifdef MEMCARD_AUTOSAVE_EN
        card_wr_pulse = 1'b1;
        step();
        card_wr_pulse = 1'b0;
        k = 1;
        while (!sd_wr && k < 400) begin
            if (k == 50) begin
                card_wr_pulse = 1'b1;
                step();
                card_wr_pulse = 1'b0;
            end else begin
                step();
            end
            k++;
        end
        check("autosave_cycle_in_150_153", 32'(k >= 150 && k <= 153), 32'd1);
        hps_serve(4, 1'b0, -1, 1'b0, shakes);
        check("autosave_shakes", 32'(shakes), 32'd4);
        step(2);
        check("autosave_dirty", 32'(dirty), 32'd0);
`else
        // CD-mode save; mode change mid-save must not shorten it
        card_wr_pulse = 1'b1;
        step();
        card_wr_pulse = 1'b0;
        check("wr_sets_dirty", 32'(dirty), 32'd1);
        SYSTEM_CDx = 1'b1;
        save_req   = 1'b1;
        step();
        save_req   = 1'b0;
        SYSTEM_CDx = 1'b0;
        check("save_clears_dirty", 32'(dirty), 32'd0);
        check("save_sd_wr",        32'(sd_wr), 32'd1);
        hps_serve(16, 1'b0, -1, 1'b0, shakes);
        check("cd_save_shakes", 32'(shakes), 32'd16);
        quiet(20, hits);
        check("cd_save_no_extra", 32'(hits), 32'd0);

        // Card write during sector 2 of a save re-dirties
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        hps_serve(4, 1'b0, 2, 1'b0, shakes);
        check("redirty_shakes", 32'(shakes), 32'd4);
        step(2);
        check("redirty_dirty", 32'(dirty), 32'd1);
        check("redirty_idle",  32'(busy),  32'd0);

        // Mount and save together: load only
        img_mounted = 1'b1;
        save_req    = 1'b1;
        step();
        img_mounted = 1'b0;
        save_req    = 1'b0;
        check("mount_clears_loaded", 32'(loaded), 32'd0);
        hps_serve(4, 1'b1, -1, 1'b0, shakes);
        check("mount_save_shakes", 32'(shakes), 32'd4);
        quiet(20, hits);
        check("mount_save_no_save", 32'(hits), 32'd0);
        check("mount_save_loaded",  32'(loaded), 32'd1);

        // Mount arriving during a save is serviced afterwards
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        hps_serve(4, 1'b0, 1, 1'b1, shakes);
        check("pend_save_shakes", 32'(shakes), 32'd4);
        hps_serve(4, 1'b1, -1, 1'b0, shakes);
        check("pend_load_shakes", 32'(shakes), 32'd4);
        step(2);
        check("pend_load_dirty", 32'(dirty), 32'd0);

        // Empty image: loaded and dirty without any transfer
        img_size_nz = 1'b0;
        img_mounted = 1'b1;
        step();
        img_mounted = 1'b0;
        check("empty_busy",   32'(busy),   32'd0);
        check("empty_loaded", 32'(loaded), 32'd1);
        check("empty_dirty",  32'(dirty),  32'd1);
        quiet(10, hits);
        check("empty_no_req", 32'(hits), 32'd0);

        // Read-only image discards saves
        img_readonly = 1'b1;
        save_req     = 1'b1;
        step();
        save_req     = 1'b0;
        quiet(20, hits);
        check("ro_no_save", 32'(hits), 32'd0);
        img_readonly = 1'b0;

        // Reset mid-request drops sd_wr before the next clock edge
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        check("pre_rst_sd_wr", 32'(sd_wr), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_sd_wr",  32'(sd_wr),  32'd0);
        check("async_rst_busy",   32'(busy),   32'd0);
        check("async_rst_loaded", 32'(loaded), 32'd0);
        step();
        reset = 1'b0;
        quiet(20, hits);
        check("post_rst_quiet", 32'(hits), 32'd0);

        // Save with nothing loaded is discarded
        save_req = 1'b1;
        step();
        save_req = 1'b0;
        quiet(20, hits);
        check("unloaded_no_save", 32'(hits), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memcard_xfer_ctrl.md
MEMCARD_XFER_CTRL -- requirements
Module: memcard_xfer_ctrl

Interface
REQ-001 SHALL have parameter AUTOSAVE_IDLE, default 24'd4_800_000, idle cycles after last card write before autosave.
REQ-002 SHALL have parameter LBA_BASE, default 32'd0, first SD sector of the card image.
REQ-003 SHALL use one clock, clk_sys; reset is asynchronous, active-high.
REQ-004 SHALL have ports:
- clk_sys  in  1  system clock
- reset  in  1  async active-high reset
- SYSTEM_CDx  in  1  1=CD mode (8kB card, 16 sectors), 0=cart mode (2kB, 4 sectors)
- card_wr_pulse  in  1  one-cycle pulse per NeoGeo-side card write
- img_mounted  in  1  one-cycle pulse, new image mounted
- img_size_nz  in  1  mounted image non-empty
- img_readonly  in  1  image is read-only
- save_req  in  1  one-cycle OSD save request
- sd_lba  out  32  sector address
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- sd_ack  in  1  HPS transfer in progress
- sd_buff_addr  in  8  word index within sector
- sd_buff_wr  in  1  HPS word write strobe
- memcard_addr  out  12  word address into card RAM
- memcard_wr  out  1  card RAM write strobe
- busy  out  1  transfer in progress
- loaded  out  1  image loaded
- dirty  out  1  card modified since last save

Function
REQ-005 SHALL implement states IDLE, LOAD_REQ, LOAD_XFER, SAVE_REQ, SAVE_XFER, NEXT.
REQ-006 Sector count N SHALL be 16 when SYSTEM_CDx=1, else 4; SYSTEM_CDx sampled at transfer start, held until return to IDLE.
REQ-007 memcard_addr SHALL equal {sector[3:0], sd_buff_addr}; memcard_wr SHALL equal sd_buff_wr & sd_ack during LOAD_XFER only, else 0.
REQ-008 sd_lba SHALL equal LBA_BASE + sector, sector counting 0..N-1.
REQ-009 IDLE->LOAD_REQ on pending mount when img_size_nz=1; if img_size_nz=0, loaded:=1, dirty:=1, no transfer.
REQ-010 LOAD_REQ/SAVE_REQ SHALL drive sd_rd/sd_wr high from the cycle after entry until sd_ack is sampled 1, then go to *_XFER.
REQ-011 *_XFER SHALL exit to NEXT on sd_ack falling edge (1 then 0).
REQ-012 NEXT SHALL increment sector and return to *_REQ if sector<N-1; else IDLE, with loaded:=1 after a load.
REQ-013 IDLE->SAVE_REQ on pending save when loaded=1, img_readonly=0, and no pending mount; dirty SHALL clear on entry to SAVE_REQ.
REQ-014 Mount has priority over save when both pending in IDLE; mount clears loaded and any pending save.
REQ-015 img_mounted or save_req while busy SHALL be latched as pending and serviced on return to IDLE; duplicate requests merge.
REQ-016 card_wr_pulse SHALL set dirty in any state, including during a save (re-dirties the card).
REQ-017 save_req with loaded=0 or img_readonly=1 SHALL be discarded.
REQ-018 busy SHALL be 1 in every state except IDLE.

Reset
REQ-019 On reset: state IDLE, sector 0, sd_rd=0, sd_wr=0, memcard_wr=0, busy=0, loaded=0, dirty=0, pendings cleared, timer 0.
REQ-020 Reset mid-transfer SHALL deassert sd_rd/sd_wr immediately (asynchronously); no resume.

Configuration
REQ-021 With MEMCARD_AUTOSAVE_EN defined: idle counter restarts on every card_wr_pulse; when dirty=1 and counter reaches AUTOSAVE_IDLE, a save request is generated internally (same rules as save_req).
REQ-022 Without MEMCARD_AUTOSAVE_EN: no counter logic; saves occur only on save_req.

Structure
REQ-023 Package memcard_pkg SHALL hold the state enum, sector-count constants (4, 16), and sector-size constant 256 words.
REQ-024 Idle counter SHALL be sub-module memcard_idle_timer, instantiated only under MEMCARD_AUTOSAVE_EN.

Verification
REQ-025 Cart mount, img_size_nz=1, HPS model writing 256 words/sector -> exactly 4 sd_rd handshakes, LBAs 0..3, loaded=1, busy=0, dirty=0.
REQ-026 SYSTEM_CDx=1, save_req after card_wr_pulse -> 16 sd_wr handshakes LBAs 0..15, dirty cleared at first SAVE_REQ.
REQ-027 card_wr_pulse during sector 2 of a save -> dirty=1 after save completes.
REQ-028 img_mounted and save_req same cycle in IDLE -> load only, save discarded.
REQ-029 Reset asserted while sd_wr=1 -> sd_wr=0 same cycle; after release, no request until new stimulus.
REQ-030 MEMCARD_AUTOSAVE_EN, AUTOSAVE_IDLE=100, one card_wr_pulse -> sd_wr asserted at cycle 101-102 after pulse; a second pulse at cycle 50 delays it to about 151.
